// File: rtl/ex_muldiv_unit.sv
// RV32M multiply/divide unit for EX: radix-2 iterative multiply and restoring divide.
// Define MULDIV_FASTMUL_EN to use a single-cycle 33x33 multiplier instead.
module ex_muldiv_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic        stall,
    output logic        result_valid,
    output logic [31:0] result
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    state_e      state_q;
    logic [5:0]  cnt_q;
    logic [2:0]  op_q;
    logic [63:0] acc_q;
    logic [31:0] opb_q;
    logic        neg_q;
    logic        nega_q;
    logic [31:0] result_q;
    logic        valid_q;

    logic        a_sgn, b_sgn;
    logic [31:0] mag_a, mag_b;
    logic        special;
    logic [31:0] spec_res;
    logic        fast;
    logic [31:0] fast_res;

    always_comb begin
        a_sgn = src_a[31] & (op[2] ? ~op[0] : (op[1:0] == 2'b01 || op[1:0] == 2'b10));
        b_sgn = src_b[31] & (op[2] ? ~op[0] : (op[1:0] == 2'b01));
        mag_a = a_sgn ? -src_a : src_a;
        mag_b = b_sgn ? -src_b : src_b;
        special = 1'b0;
        spec_res = 32'hFFFF_FFFF;
        if (op[2] && src_b == 32'd0) begin
            special = 1'b1;
            spec_res = op[1] ? src_a : 32'hFFFF_FFFF;
        end else if (op[2] && !op[0] && src_a == 32'h8000_0000
                     && src_b == 32'hFFFF_FFFF) begin
            special = 1'b1;
            spec_res = op[1] ? 32'd0 : 32'h8000_0000;
        end
    end

`ifdef MULDIV_FASTMUL_EN
    logic signed [65:0] fa, fb, fprod;
    always_comb begin
        fa = {{34{a_sgn}}, src_a};
        fb = {{34{b_sgn}}, src_b};
        fprod = fa * fb;
        fast = ~op[2];
        fast_res = (op[1:0] == 2'b00) ? fprod[31:0] : fprod[63:32];
    end
`else
    assign fast = 1'b0;
    assign fast_res = 32'd0;
`endif

    // One radix-2 step: acc holds {hi, lo} = {partial/remainder, multiplier/quotient}
    logic [32:0] madd;
    logic [64:0] sh;
    logic [32:0] trial;
    logic [63:0] step, prod;
    logic [31:0] quo, rem, fin;

    always_comb begin
        madd  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opb_q} : 33'd0);
        sh    = {acc_q, 1'b0};
        trial = sh[64:32] - {1'b0, opb_q};
        if (op_q[2])
            step = trial[32] ? sh[63:0] : {trial[31:0], sh[31:1], 1'b1};
        else
            step = {madd, acc_q[31:1]};
        prod = neg_q ? -step : step;
        quo  = neg_q ? -step[31:0] : step[31:0];
        rem  = nega_q ? -step[63:32] : step[63:32];
        unique case (op_q)
            3'b000:  fin = prod[31:0];
            3'b001, 3'b010, 3'b011: fin = prod[63:32];
            3'b100, 3'b101: fin = quo;
            default: fin = rem;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= 6'd0;
            op_q     <= 3'd0;
            acc_q    <= 64'd0;
            opb_q    <= 32'd0;
            neg_q    <= 1'b0;
            nega_q   <= 1'b0;
            result_q <= 32'd0;
            valid_q  <= 1'b0;
        end else if (flush) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        op_q   <= op;
                        cnt_q  <= 6'd0;
                        neg_q  <= a_sgn ^ b_sgn;
                        nega_q <= a_sgn;
                        acc_q  <= {32'd0, op[2] ? mag_a : mag_b};
                        opb_q  <= op[2] ? mag_b : mag_a;
                        if (special) begin
                            result_q <= spec_res;
                            valid_q  <= 1'b1;
                            state_q  <= DONE;
                        end else if (fast) begin
                            result_q <= fast_res;
                            valid_q  <= 1'b1;
                            state_q  <= DONE;
                        end else begin
                            state_q <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    acc_q <= step;
                    cnt_q <= cnt_q + 6'd1;
                    if (cnt_q == 6'd31) begin
                        result_q <= fin;
                        valid_q  <= 1'b1;
                        state_q  <= DONE;
                    end
                end
                DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign stall = !flush && ((state_q == IDLE && start) || state_q == BUSY);
    assign result_valid = valid_q;
    assign result = result_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Randomized self-checking bench for ex_muldiv_unit against a 64-bit arithmetic model.
// Honours MULDIV_FASTMUL_EN for expected multiply latency.
module tb_ex_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst, flush, start;
    logic [2:0]  op;
    logic [31:0] src_a, src_b;
    logic        stall, result_valid;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;
    int dones = 0;
    int nops = 0;
    logic [31:0] last_res;

    ex_muldiv_unit dut (
        .clk(clk), .rst(rst), .flush(flush), .start(start), .op(op),
        .src_a(src_a), .src_b(src_b), .stall(stall),
        .result_valid(result_valid), .result(result)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (result_valid) dones++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
        int ia, ib;
        longint sa, sb, sub, p;
        longint unsigned ua, ub, pu;
        logic [31:0] r;
        ia = a; ib = b;
        sa = ia; sb = ib;
        ua = a; ub = b; sub = b;
        r = 32'd0;
        case (o)
            3'd0: begin p = sa * sb; r = p[31:0]; end
            3'd1: begin p = sa * sb; r = p[63:32]; end
            3'd2: begin p = sa * sub; r = p[63:32]; end
            3'd3: begin pu = ua * ub; r = pu[63:32]; end
            default: begin
                if (b == 32'd0)
                    r = o[1] ? a : 32'hFFFF_FFFF;
                else if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                    r = o[1] ? 32'd0 : 32'h8000_0000;
                else if (o == 3'd4) r = ia / ib;
                else if (o == 3'd6) r = ia % ib;
                else if (o == 3'd5) r = a / b;
                else r = a % b;
            end
        endcase
        return r;
    endfunction

    function automatic int exp_lat(input logic [2:0] o, input logic [31:0] a,
                                   input logic [31:0] b);
        bit sp, fst;
        sp = o[2] && (b == 32'd0 ||
             (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
`ifdef MULDIV_FASTMUL_EN
        fst = !o[2];
`else
        fst = 1'b0;
`endif
        return (sp || fst) ? 1 : 33;
    endfunction

    // Called just after a falling edge; returns at the falling edge inside DONE.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input bit hold);
        int n;
        bit got;
        logic [31:0] e;
        int lat;
        e = model(o, a, b);
        lat = exp_lat(o, a, b);
        op = o; src_a = a; src_b = b; start = 1'b1;
        n = 0; got = 1'b0;
        for (int i = 0; i < 80 && !got; i++) begin
            #1;
            if (stall) n++;
            @(negedge clk);
            if (result_valid) got = 1'b1;
            else check("hold", result, last_res);
        end
        check("valid", 32'(got), 32'd1);
        check($sformatf("res op%0d %h %h", o, a, b), result, e);
        check($sformatf("stall op%0d", o), 32'(n), 32'(lat));
        last_res = e;
        nops++;
        if (!hold) start = 1'b0;
    endtask

    logic [2:0]  d_op [12] = '{3'd0, 3'd3, 3'd1, 3'd2, 3'd4, 3'd6,
                               3'd5, 3'd7, 3'd5, 3'd7, 3'd4, 3'd6};
    logic [31:0] d_a  [12] = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                               32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100,
                               32'h1234, 32'h1234, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] d_b  [12] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2,
                               32'd2, 32'd2, 32'd7, 32'd7,
                               32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};

    initial begin
        rst = 1'b1; flush = 1'b0; start = 1'b0;
        op = 3'd0; src_a = 32'd0; src_b = 32'd0; last_res = 32'd0;
        #1;
        check("rst_result", result, 32'd0);
        check("rst_valid", 32'(result_valid), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1 check("idle_stall", 32'(stall), 32'd0);
        @(negedge clk);

        for (int i = 0; i < 12; i++) run_op(d_op[i], d_a[i], d_b[i], 1'b0);

        for (int i = 0; i < 40; i++) begin
            logic [2:0]  ro;
            logic [31:0] ra, rb;
            ro = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = 32'($urandom_range(1, 20));
                default: ;
            endcase
            run_op(ro, ra, rb, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) begin
                start = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
        end
        start = 1'b0;
        @(negedge clk);

        op = 3'd5; src_a = 32'hDEAD_BEEF; src_b = 32'd3; start = 1'b1;
        repeat (11) @(negedge clk);
        flush = 1'b1; start = 1'b0;
        @(negedge clk);
        flush = 1'b0;
        #1 check("flush_stall", 32'(stall), 32'd0);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            check("flush_valid", 32'(result_valid), 32'd0);
            check("flush_result", result, last_res);
        end

        op = 3'd5; src_a = 32'h7777_7777; src_b = 32'd5; start = 1'b1;
        repeat (21) @(negedge clk);
        rst = 1'b1; start = 1'b0;
        #1;
        check("rst_mid_result", result, 32'd0);
        check("rst_mid_valid", 32'(result_valid), 32'd0);
        check("rst_mid_stall", 32'(stall), 32'd0);
        last_res = 32'd0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_op(3'd5, 32'd100, 32'd7, 1'b1);
        run_op(3'd7, 32'd100, 32'd7, 1'b1);
        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 1'b0);
        repeat (3) @(negedge clk);

        check("done_count", 32'(dones), 32'(nops));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
